mux_serializer: RTL
===================

// Module: mux_serializer
// PURPOSE
//  Parallel-to-serial stage that feeds a muxNto1 instance. It accepts a WIDTH-bit word over a
//  valid/ready handshake and registers it. It then steps the mux select through every bit
//  position, one bit per accepted serial transfer. Sits directly upstream of muxNto1: it owns
//  the data word and sel, instantiates muxNto1 #(WIDTH) internally, and presents out as ser_bit.
// PARAMETERS
//  WIDTH      16               word width / mux inputs, >= 2
//  SEL_WIDTH  $clog2(WIDTH)    select width, derived, do not override
//  MSB_FIRST  0                0: sel counts 0..WIDTH-1; 1: sel counts WIDTH-1..0
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          async active-high reset
//  in_data    in   WIDTH      parallel word to serialize
//  in_valid   in   1          in_data valid
//  in_ready   out  1          word accepted when in_valid && in_ready at clk edge
//  ser_bit    out  1          muxNto1 output = word_q[sel_q]
//  ser_valid  out  1          ser_bit valid
//  ser_ready  in   1          downstream accepts ser_bit when ser_valid && ser_ready
//  ser_sel    out  SEL_WIDTH  current select (sel_q), exported for checking
//  ser_first  out  1          ser_valid && sel_q is the first position of the word
//  ser_last   out  1          ser_valid && sel_q is the last position of the word
//  word_cnt   out  16         completed words, wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; word_q=0; word_cnt=0.
//    sel_q = start position (0, or WIDTH-1 if MSB_FIRST).
//    Reset mid-word discards the remaining bits and does not count the word.
//    in_ready=1 and ser_valid=0 while rst is high.
//  - States: IDLE, SHIFT.
//  - IDLE: in_ready=1, ser_valid=0, ser_first=0, ser_last=0. On in_valid: word_q<=in_data,
//    sel_q<=start position, go to SHIFT. ser_valid is high the cycle after acceptance
//    (latency 1).
//  - SHIFT: ser_valid=1. ser_bit is combinational from word_q/sel_q through muxNto1.
//  - Serial transfer (ser_ready=1) at a non-last position: sel_q steps +1 (or -1 if MSB_FIRST).
//    With ser_ready=0, sel_q, word_q and ser_bit hold stable with no limit.
//  - in_ready in SHIFT = ser_ready && ser_last (combinational). in_data is never accepted
//    mid-word.
//  - Transfer at the last position: word_cnt+1. If in_valid in the same cycle, load the new
//    word, reset sel_q to start and stay in SHIFT (back-to-back, no bubble). Otherwise go to
//    IDLE and keep sel_q at the last position.
//  - word_q is written only on acceptance. Changes on in_data outside acceptance are ignored.
//  - Throughput: one bit per cycle at full ser_ready; WIDTH cycles per word back-to-back.
//  - No X on any output after reset. sel_q never leaves 0..WIDTH-1 (WIDTH not a power of 2
//    included).
// TESTING
//  1. Reset, in_data=16'hA5C3 with in_valid pulsed 1 cycle, ser_ready=1 ->
//     ser_bit = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles (LSB first).
//     ser_first on bit 0, ser_last on bit 15; word_cnt=1; returns to IDLE.
//  2. MSB_FIRST=1, same word -> bits emitted 15..0 (1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1);
//     ser_sel counts 15..0.
//  3. Back-to-back: in_valid held with 16'hFFFF then 16'h0000 -> 32 consecutive ser_valid
//     cycles (16 ones, then 16 zeros); in_ready high only on the last-bit cycles;
//     word_cnt=2.
//  4. Backpressure: ser_ready low for 5 cycles at sel=7 of one-hot word 16'h0080 ->
//     ser_bit=1 and ser_sel=7 held all 5 cycles; every other position yields 0.
//  5. Walking one: for i in 0..15 send 1<<i -> ser_bit==(sel==i) at every transfer,
//     matching muxNto1 pattern behaviour.
//  6. rst asserted at sel=9 mid-word -> immediately ser_valid=0, in_ready=1, sel=0;
//     word_cnt unchanged from 0; next word serializes correctly from bit 0.

Source files
------------

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: registers a word over valid/ready, then walks the muxNto1 select
// across every bit position, one bit per accepted serial transfer.
module mux_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_WIDTH = $clog2(WIDTH),
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ser_bit,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic [SEL_WIDTH-1:0] ser_sel,
  output logic                 ser_first,
  output logic                 ser_last,
  output logic [15:0]          word_cnt
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [SEL_WIDTH-1:0] SelFirst = MSB_FIRST ? SEL_WIDTH'(WIDTH - 1) : '0;
  localparam logic [SEL_WIDTH-1:0] SelLast  = MSB_FIRST ? '0 : SEL_WIDTH'(WIDTH - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     word_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [15:0]          word_cnt_q;

  assign ser_valid = (state_q == StShift);
  assign ser_first = ser_valid && (sel_q == SelFirst);
  assign ser_last  = ser_valid && (sel_q == SelLast);
  // A new word can only enter while idle or as the last bit of the current word leaves.
  assign in_ready  = (state_q == StIdle) || (ser_ready && ser_last);
  assign ser_sel   = sel_q;
  assign word_cnt  = word_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      sel_q      <= SelFirst;
      word_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            word_q  <= in_data;
            sel_q   <= SelFirst;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (ser_ready) begin
            if (sel_q == SelLast) begin
              word_cnt_q <= word_cnt_q + 16'd1;
              if (in_valid) begin
                word_q <= in_data;
                sel_q  <= SelFirst;
              end else begin
                state_q <= StIdle;
              end
            end else if (MSB_FIRST) begin
              sel_q <= sel_q - 1'b1;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  muxNto1 #(
    .WIDTH    (WIDTH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_mux (
    .data(word_q),
    .sel (sel_q),
    .out (ser_bit)
  );

endmodule

// N-to-1 bit multiplexer; out-of-range selects yield 0.
module muxNto1 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SEL_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     data,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic                 out
);

  always_comb begin
    out = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_WIDTH'(i)) out = data[i];
    end
  end

endmodule
